// File: rtl/fft_bfly_stage.sv
// fft_bfly_stage: radix-2 delay-feedback butterfly that sits after the
// 16-lane delay line of an FFT stage. Each beat in the compute half of a frame
// is paired with the beat D = MEM_DEPTH/16 valid beats earlier (presented on
// shift_data_*). The registered outputs are sum = delayed + current and
// diff = delayed - current.
// Optional build macro BFLY_SCALE_EN: results are halved with round-half-up
// and saturated to WIDTH bits. Without it, results are exact at WIDTH+1 bits.
module fft_bfly_stage #(
  parameter int WIDTH     = 9,
  parameter int MEM_DEPTH = 256,
`ifdef BFLY_SCALE_EN
  localparam int OUT_W    = WIDTH
`else
  localparam int OUT_W    = WIDTH + 1
`endif
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic signed [WIDTH-1:0] din_re        [0:15],
  input  logic signed [WIDTH-1:0] din_im        [0:15],
  input  logic                    valid,
  input  logic signed [WIDTH-1:0] shift_data_re [0:15],
  input  logic signed [WIDTH-1:0] shift_data_im [0:15],
  input  logic                    sync_clr,
  output logic signed [OUT_W-1:0] sum_re        [0:15],
  output logic signed [OUT_W-1:0] sum_im        [0:15],
  output logic signed [OUT_W-1:0] diff_re       [0:15],
  output logic signed [OUT_W-1:0] diff_im       [0:15],
  output logic                    out_valid,
  output logic                    frame_last
);

  localparam int D     = MEM_DEPTH / 16;
  localparam int CNT_W = $clog2(2 * D);
  localparam logic [CNT_W-1:0] D_CNT    = CNT_W'(D);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * D - 1);

  logic [CNT_W-1:0]        beat_cnt_q,   beat_cnt_d;
  logic                    out_valid_q,  out_valid_d;
  logic                    frame_last_q, frame_last_d;
  logic signed [OUT_W-1:0] sum_re_q  [0:15], sum_re_d  [0:15];
  logic signed [OUT_W-1:0] sum_im_q  [0:15], sum_im_d  [0:15];
  logic signed [OUT_W-1:0] diff_re_q [0:15], diff_re_d [0:15];
  logic signed [OUT_W-1:0] diff_im_q [0:15], diff_im_d [0:15];

  // One-bit sign extension so the add/subtract can never overflow.
  function automatic logic signed [WIDTH:0] sext(input logic signed [WIDTH-1:0] x);
    return {x[WIDTH-1], x};
  endfunction

`ifdef BFLY_SCALE_EN
  // Halve with round-half-up, then clamp; only +2^(WIDTH-1) can fall out of range.
  function automatic logic signed [OUT_W-1:0] shape(input logic signed [WIDTH:0] x);
    logic signed [WIDTH+1:0] t;
    t = {x[WIDTH], x} + (WIDTH+2)'(1);
    t = t >>> 1;
    if (t[WIDTH+1:WIDTH-1] != {3{t[WIDTH+1]}})
      return {t[WIDTH+1], {(WIDTH-1){~t[WIDTH+1]}}};
    return t[WIDTH-1:0];
  endfunction
`else
  // Exact result: the sign-extended sum already fits OUT_W bits.
  function automatic logic signed [OUT_W-1:0] shape(input logic signed [WIDTH:0] x);
    return x;
  endfunction
`endif

  // Next-state: frame counter, output strobes and butterfly results (held otherwise).
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    out_valid_d  = 1'b0;
    frame_last_d = 1'b0;
    sum_re_d     = sum_re_q;
    sum_im_d     = sum_im_q;
    diff_re_d    = diff_re_q;
    diff_im_d    = diff_im_q;
    if (sync_clr) begin
      beat_cnt_d = '0;
    end else if (valid) begin
      beat_cnt_d = (beat_cnt_q == LAST_CNT) ? '0 : beat_cnt_q + 1'b1;
      if (beat_cnt_q >= D_CNT) begin
        out_valid_d  = 1'b1;
        frame_last_d = (beat_cnt_q == LAST_CNT);
        for (int k = 0; k < 16; k++) begin
          sum_re_d[k]  = shape(sext(shift_data_re[k]) + sext(din_re[k]));
          sum_im_d[k]  = shape(sext(shift_data_im[k]) + sext(din_im[k]));
          diff_re_d[k] = shape(sext(shift_data_re[k]) - sext(din_re[k]));
          diff_im_d[k] = shape(sext(shift_data_im[k]) - sext(din_im[k]));
        end
      end
    end
  end

  // State and output registers, cleared asynchronously by rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_last_q <= 1'b0;
      sum_re_q     <= '{default: '0};
      sum_im_q     <= '{default: '0};
      diff_re_q    <= '{default: '0};
      diff_im_q    <= '{default: '0};
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      out_valid_q  <= out_valid_d;
      frame_last_q <= frame_last_d;
      sum_re_q     <= sum_re_d;
      sum_im_q     <= sum_im_d;
      diff_re_q    <= diff_re_d;
      diff_im_q    <= diff_im_d;
    end
  end

  assign sum_re     = sum_re_q;
  assign sum_im     = sum_im_q;
  assign diff_re    = diff_re_q;
  assign diff_im    = diff_im_q;
  assign out_valid  = out_valid_q;
  assign frame_last = frame_last_q;

endmodule
